// File: rtl/qcw_ramp_ctrl_if.sv
// rtl/qcw_ramp_ctrl_if.sv - PLL bridge control bus between ramp controller and PLL
interface qcw_ramp_ctrl_if;
  logic        pll_start;
  logic [7:0]  pll_phase_shift;
  logic [15:0] pll_cycle_limit;
  logic        pll_cycle_finished;
  logic        pll_fault;

  modport master (
    output pll_start,
    output pll_phase_shift,
    output pll_cycle_limit,
    input  pll_cycle_finished,
    input  pll_fault
  );

  modport slave (
    input  pll_start,
    input  pll_phase_shift,
    input  pll_cycle_limit,
    output pll_cycle_finished,
    output pll_fault
  );
endinterface

// File: rtl/qcw_ramp_ctrl.sv
// rtl/qcw_ramp_ctrl.sv - QCW shot sequencer: phase ramp, hold, watchdog, fault latch and off-time
module qcw_ramp_ctrl #(
  parameter int MIN_OFF_CYCLES = 1000000,
  parameter int RUN_TIMEOUT    = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fire,
  input  logic                   abort,
  input  logic                   fault_clear,
  input  logic [7:0]             ramp_start,
  input  logic [7:0]             ramp_end,
  input  logic [7:0]             ramp_step,
  input  logic [15:0]            hold_cycles,
  qcw_ramp_ctrl_if.master        pll,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic                   fault_latched
);

  localparam int OFF_W = $clog2(MIN_OFF_CYCLES + 1);
  localparam int WD_W  = $clog2(RUN_TIMEOUT + 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(MIN_OFF_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_START, S_RAMP, S_HOLD, S_COOLDOWN, S_FAULT
  } state_t;

  state_t state, state_nxt;

  logic             fire_prev;
  logic [7:0]       cfg_start, cfg_end, cfg_step;
  logic [15:0]      cfg_hold;
  logic [7:0]       rem;
  logic [7:0]       ramp_cycles;
  logic [15:0]      limit;
  logic [7:0]       phase;
  logic [15:0]      run_cnt;
  logic [WD_W-1:0]  wd;
  logic [OFF_W-1:0] off_cnt;
  logic             done_q, cfg_err_q;

  logic             fire_edge, cfg_ok;
  logic [16:0]      limit_sum;
  logic [15:0]      limit_sat;
  logic [8:0]       phase_sum;
  logic [7:0]       phase_nxt;
  logic [15:0]      run_nxt;
  logic             run_hit, wd_expired;
  logic             pulse_done, pulse_cfg_err;
  logic             run_state;

  assign fire_edge  = fire & ~fire_prev;
  assign cfg_ok     = (ramp_step != 8'd0) && (ramp_end >= ramp_start) && !fault_latched;
  assign limit_sum  = {9'd0, ramp_cycles} + {1'b0, cfg_hold};
  assign limit_sat  = limit_sum[16] ? 16'hFFFF : limit_sum[15:0];
  // 9-bit sum so a step past 255 clamps to ramp_end instead of wrapping
  assign phase_sum  = {1'b0, phase} + {1'b0, cfg_step};
  assign phase_nxt  = (phase_sum > {1'b0, cfg_end}) ? cfg_end : phase_sum[7:0];
  assign run_nxt    = run_cnt + 16'd1;
  assign run_hit    = (run_nxt == limit);
  assign wd_expired = (wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pulse_done    = 1'b0;
    pulse_cfg_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (fire_edge) begin
          if (cfg_ok) state_nxt = S_CALC;
          else        pulse_cfg_err = 1'b1;
        end
      end
      S_CALC: begin
        if (pll.pll_fault)   state_nxt = S_FAULT;
        else if (abort)      state_nxt = S_COOLDOWN;
        else if (rem == 8'd0) begin
          if (limit_sat == 16'd0) begin
            pulse_done = 1'b1;
            state_nxt  = S_COOLDOWN;
          end else begin
            state_nxt  = S_START;
          end
        end
      end
      S_START: begin
        if (pll.pll_fault)          state_nxt = S_FAULT;
        else if (abort)             state_nxt = S_COOLDOWN;
        else if (ramp_cycles == 8'd0) state_nxt = S_HOLD;
        else                        state_nxt = S_RAMP;
      end
      S_RAMP, S_HOLD: begin
        if (pll.pll_fault) state_nxt = S_FAULT;
        else if (abort)    state_nxt = S_COOLDOWN;
        else if (pll.pll_cycle_finished) begin
          if (run_hit) begin
            pulse_done = 1'b1;
            state_nxt  = S_COOLDOWN;
          end else if (state == S_RAMP && phase_nxt == cfg_end) begin
            state_nxt  = S_HOLD;
          end
        end else if (wd_expired) begin
          state_nxt = S_FAULT;
        end
      end
      S_COOLDOWN: begin
        if (off_cnt == OFF_LAST) state_nxt = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clear && !pll.pll_fault) state_nxt = S_COOLDOWN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_prev   <= 1'b1;
      cfg_start   <= 8'd0;
      cfg_end     <= 8'd0;
      cfg_step    <= 8'd0;
      cfg_hold    <= 16'd0;
      rem         <= 8'd0;
      ramp_cycles <= 8'd0;
      limit       <= 16'd0;
      phase       <= 8'd0;
      run_cnt     <= 16'd0;
      wd          <= '0;
      off_cnt     <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      fire_prev <= fire;
      done_q    <= pulse_done;
      cfg_err_q <= pulse_cfg_err;
      if (state != S_COOLDOWN) off_cnt <= '0;
      case (state)
        S_IDLE: begin
          if (fire_edge && cfg_ok) begin
            cfg_start   <= ramp_start;
            cfg_end     <= ramp_end;
            cfg_step    <= ramp_step;
            cfg_hold    <= hold_cycles;
            rem         <= ramp_end - ramp_start;
            ramp_cycles <= 8'd0;
          end
        end
        // One subtraction per clock keeps the divider out of the datapath
        S_CALC: begin
          if (rem != 8'd0) begin
            rem         <= (rem > cfg_step) ? rem - cfg_step : 8'd0;
            ramp_cycles <= ramp_cycles + 8'd1;
          end else begin
            limit <= limit_sat;
            phase <= cfg_start;
          end
        end
        S_START: begin
          run_cnt <= 16'd0;
          wd      <= '0;
        end
        S_RAMP, S_HOLD: begin
          if (pll.pll_cycle_finished) begin
            run_cnt <= run_nxt;
            wd      <= '0;
            if (state == S_RAMP) phase <= phase_nxt;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        S_COOLDOWN: off_cnt <= off_cnt + OFF_W'(1);
        default: ;
      endcase
    end
  end

  // PLL-facing outputs decode straight from state so reset stops the bridge at once
  always_comb begin
    run_state           = (state == S_START) || (state == S_RAMP) || (state == S_HOLD);
    pll.pll_start       = (state == S_START);
    pll.pll_phase_shift = run_state ? phase : 8'd0;
    pll.pll_cycle_limit = run_state ? limit : 16'd0;
    busy                = (state != S_IDLE);
    fault_latched       = (state == S_FAULT);
    done                = done_q;
    cfg_err             = cfg_err_q;
  end

endmodule
